// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encodings, FSM states and defaults for seq_alu
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SLL   = 4'b0001,
        OP_SLTU  = 4'b0010,
        OP_SLT   = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_OR    = 4'b0110,
        OP_AND   = 4'b0111,
        OP_SUB   = 4'b1000,
        OP_MUL   = 4'b1001,
        OP_MULHU = 4'b1010,
        OP_DIVU  = 4'b1011,
        OP_REMU  = 4'b1100,
        OP_SRA   = 4'b1101
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/response handshake bundle between operand fetch and seq_alu
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow
    );
endinterface

// File: rtl/seq_alu_muldiv.sv
// rtl/seq_alu_muldiv.sv - iterative unsigned shift-add multiplier and restoring divider
module seq_alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);

    logic               busy;
    logic               is_div;
    logic               hi_sel;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     madd;
    logic [WIDTH:0]     rtmp;
    logic [WIDTH:0]     rdiff;
    logic               qbit;

    // prod holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        madd  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        rtmp  = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        rdiff = rtmp - {1'b0, operand};
        qbit  = ~rdiff[WIDTH];
        if (is_div) begin
            prod_next = {(qbit ? rdiff[WIDTH-1:0] : rtmp[WIDTH-1:0]), prod[WIDTH-2:0], qbit};
        end else begin
            prod_next = {madd, prod[WIDTH-1:1]};
        end
    end

    // A zero divisor always "fits", giving all-ones quotient and remainder = dividend
    assign done   = busy && (cnt == '0);
    assign result = hi_sel ? prod_next[2*WIDTH-1:WIDTH] : prod_next[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            is_div  <= 1'b0;
            hi_sel  <= 1'b0;
            cnt     <= '0;
            operand <= '0;
            prod    <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= CW'(WIDTH - 1);
            is_div  <= (op == OP_DIVU) || (op == OP_REMU);
            hi_sel  <= (op == OP_MULHU) || (op == OP_REMU);
            if ((op == OP_DIVU) || (op == OP_REMU)) begin
                operand <= b;
                prod    <= {{WIDTH{1'b0}}, a};
            end else begin
                operand <= a;
                prod    <= {{WIDTH{1'b0}}, b};
            end
        end else if (busy) begin
            prod <= prod_next;
            cnt  <= cnt - CW'(1);
            if (cnt == '0) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU: single-cycle datapath, control FSM and registered outputs
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int SHW   = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst_n,
    seq_alu_if.slave  bus
);
    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             carry_q;
    logic             overflow_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [SHW-1:0]   shamt;
    logic             accept;
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    assign shamt  = bus.b[SHW-1:0];
    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        add_sum  = {1'b0, bus.a} + {1'b0, bus.b};
        sub_diff = {1'b0, bus.a} - {1'b0, bus.b};
        case (bus.op)
            OP_ADD: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            // carry on subtract is the borrow, i.e. a < b unsigned
            OP_SUB: begin
                alu_res = sub_diff[WIDTH-1:0];
                alu_c   = sub_diff[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLL:  alu_res = bus.a << shamt;
            OP_SRL:  alu_res = bus.a >> shamt;
            OP_SRA:  alu_res = $signed(bus.a) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_AND:  alu_res = bus.a & bus.b;
            default: alu_res = '0;
        endcase
    end

    seq_alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && is_iterative(bus.op)),
        .op     (bus.op),
        .a      (bus.a),
        .b      (bus.b),
        .done   (md_done),
        .result (md_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (is_iterative(bus.op)) begin
                            state <= ST_BUSY;
                        end else begin
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            carry_q     <= alu_c;
                            overflow_q  <= alu_v;
                            out_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        result_q    <= md_result;
                        zero_q      <= (md_result == '0);
                        carry_q     <= 1'b0;
                        overflow_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu at WIDTH=32 and WIDTH=8
module tb_seq_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) b32 ();
    seq_alu_if #(.WIDTH(8))  b8 ();

    seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int w, input logic iv, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        if (w == 32) begin
            b32.in_valid = iv; b32.op = op; b32.a = a; b32.b = b;
        end else begin
            b8.in_valid = iv; b8.op = op; b8.a = a[7:0]; b8.b = b[7:0];
        end
    endtask

    task automatic set_ordy(input int w, input logic r);
        if (w == 32) b32.out_ready = r;
        else         b8.out_ready  = r;
    endtask

    function automatic logic [31:0] get_res(input int w);
        return (w == 32) ? b32.result : {24'b0, b8.result};
    endfunction

    function automatic logic [2:0] get_zcv(input int w);
        return (w == 32) ? {b32.zero, b32.carry, b32.overflow} : {b8.zero, b8.carry, b8.overflow};
    endfunction

    function automatic logic get_ov(input int w);
        return (w == 32) ? b32.out_valid : b8.out_valid;
    endfunction

    function automatic logic get_rdy(input int w);
        return (w == 32) ? b32.in_ready : b8.in_ready;
    endfunction

    // Accept edge counts as latency 1; bounded wait for out_valid
    task automatic issue(input int w, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output int rdy_seen);
        @(negedge clk);
        set_in(w, 1'b1, op, a, b);
        @(posedge clk); #1;
        set_in(w, 1'b0, op, a, b);
        lat = 1;
        rdy_seen = 0;
        while (!get_ov(w) && lat < 200) begin
            if (get_rdy(w)) rdy_seen++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack(input int w);
        @(negedge clk);
        set_ordy(w, 1'b1);
        @(posedge clk); #1;
        set_ordy(w, 1'b0);
    endtask

    task automatic do_op(input int w, input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [2:0] exp_zcv, input int exp_lat);
        int lat, rdy_seen;
        issue(w, op, a, b, lat, rdy_seen);
        chk($sformatf("w%0d_%s_lat", w, tag), lat, exp_lat);
        chk($sformatf("w%0d_%s_res", w, tag), get_res(w), exp_res);
        chk($sformatf("w%0d_%s_zcv", w, tag), {29'b0, get_zcv(w)}, {29'b0, exp_zcv});
        chk($sformatf("w%0d_%s_busy_rdy", w, tag), rdy_seen, 0);
        ack(w);
    endtask

    task automatic run_set(input int w);
        logic [31:0] all, msb, maxpos, sra_exp;
        int ilat, iters;
        all     = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        msb     = (w == 32) ? 32'h8000_0000 : 32'h0000_0080;
        maxpos  = (w == 32) ? 32'h7FFF_FFFF : 32'h0000_007F;
        sra_exp = (w == 32) ? 32'hF800_0000 : 32'h0000_00F8;
        ilat    = (w == 32) ? 33 : 9;
        iters   = (w == 32) ? 10 : 5;

        do_op(w, "add_ovf",   OP_ADD,  maxpos, 1, msb,    3'b001, 1);
        do_op(w, "add_carry", OP_ADD,  all,    1, 0,      3'b110, 1);
        do_op(w, "sub_ovf",   OP_SUB,  msb,    1, maxpos, 3'b001, 1);
        do_op(w, "sub_borrow",OP_SUB,  1,      2, all,    3'b010, 1);
        do_op(w, "slt",       OP_SLT,  all,    1, 1,      3'b000, 1);
        do_op(w, "sltu",      OP_SLTU, all,    1, 0,      3'b100, 1);
        do_op(w, "xor",       OP_XOR,  8'hA5,  8'h0F, 8'hAA, 3'b000, 1);
        do_op(w, "or",        OP_OR,   8'hF0,  8'h0F, 8'hFF, 3'b000, 1);
        do_op(w, "and",       OP_AND,  8'hF0,  8'h0F, 0,     3'b100, 1);
        do_op(w, "sll_mask",  OP_SLL,  3,      w + 1, 6,     3'b000, 1);
        do_op(w, "srl",       OP_SRL,  msb,    w - 1, 1,     3'b000, 1);
        do_op(w, "undef",     4'hE,    5,      5,     0,     3'b100, 1);
        do_op(w, "mul",       OP_MUL,  all,    2, all - 1, 3'b000, ilat);
        do_op(w, "mulhu",     OP_MULHU,all,    2, 1,       3'b000, ilat);
        do_op(w, "divu",      OP_DIVU, 100,    7, 14,      3'b000, ilat);
        do_op(w, "remu",      OP_REMU, 100,    7, 2,       3'b000, ilat);
        do_op(w, "divu_z",    OP_DIVU, 8'h55,  0, all,     3'b000, ilat);
        do_op(w, "remu_z",    OP_REMU, 5,      0, 5,       3'b000, ilat);

        // Backpressure: result held, second request waits for the handshake
        begin
            int lat, rdy_seen;
            issue(w, OP_SRA, msb, 4, lat, rdy_seen);
            chk($sformatf("w%0d_sra_lat", w), lat, 1);
            chk($sformatf("w%0d_sra_res", w), get_res(w), sra_exp);
            @(negedge clk);
            set_in(w, 1'b1, OP_ADD, 2, 3);
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                chk($sformatf("w%0d_bp_res_%0d", w, i), get_res(w), sra_exp);
                chk($sformatf("w%0d_bp_ov_%0d", w, i), get_ov(w), 1);
                chk($sformatf("w%0d_bp_rdy_%0d", w, i), get_rdy(w), 0);
            end
            @(negedge clk);
            set_ordy(w, 1'b1);
            @(posedge clk); #1;
            set_ordy(w, 1'b0);
            chk($sformatf("w%0d_bp_hs_ov", w), get_ov(w), 0);
            chk($sformatf("w%0d_bp_hs_rdy", w), get_rdy(w), 1);
            @(posedge clk); #1;
            set_in(w, 1'b0, OP_ADD, 2, 3);
            chk($sformatf("w%0d_bp_next_ov", w), get_ov(w), 1);
            chk($sformatf("w%0d_bp_next_res", w), get_res(w), 5);
            ack(w);
        end

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        set_in(w, 1'b1, OP_DIVU, 100, 7);
        @(posedge clk); #1;
        set_in(w, 1'b0, OP_DIVU, 100, 7);
        repeat (iters) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk($sformatf("w%0d_rst_ov", w), get_ov(w), 0);
        chk($sformatf("w%0d_rst_rdy", w), get_rdy(w), 0);
        chk($sformatf("w%0d_rst_res", w), get_res(w), 0);
        chk($sformatf("w%0d_rst_zcv", w), {29'b0, get_zcv(w)}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("w%0d_rel_rdy", w), get_rdy(w), 1);
        chk($sformatf("w%0d_rel_ov", w), get_ov(w), 0);
        do_op(w, "post_rst_add", OP_ADD, 2, 3, 5, 3'b000, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(32, 1'b0, 4'h0, 0, 0);
        set_in(8,  1'b0, 4'h0, 0, 0);
        set_ordy(32, 1'b0);
        set_ordy(8,  1'b0);
        repeat (2) @(negedge clk);
        chk("reset_ov32",  get_ov(32), 0);
        chk("reset_rdy32", get_rdy(32), 0);
        chk("reset_res32", get_res(32), 0);
        chk("reset_zcv32", {29'b0, get_zcv(32)}, 0);
        chk("reset_ov8",   get_ov(8), 0);
        chk("reset_res8",  get_res(8), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_rdy32", get_rdy(32), 1);
        chk("release_rdy8",  get_rdy(8), 1);

        run_set(32);
        run_set(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
